// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 keyboard receiver.
// FIFO geometry, frame length, scan codes used by benches, and the
// odd-parity helper used by the frame validator.
package ps2_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int PTR_W      = 3;
  localparam int FRAME_BITS = 11;
  localparam int CNT_W      = 4;

  // Index of the stop bit; reaching it closes the frame.
  localparam logic [CNT_W-1:0] LAST_BIT = 4'd10;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] KEY_A      = 8'h1C;
  localparam logic [7:0] KEY_S      = 8'h1B;

  // True when data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_sync.sv
// ps2_clk_sync: brings the keyboard clock into the clk domain through
// three flops and emits a one-cycle pulse on each falling edge.
import ps2_pkg::*;

module ps2_clk_sync (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  output logic fall
);

  logic [2:0] sync_r;

  // Shift the raw PS/2 clock through the synchroniser; idle level is high.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_r <= 3'b111;
    end else begin
      sync_r <= {sync_r[1:0], ps2_clk};
    end
  end

  // Older sample high, newer sample low marks a falling edge.
  assign fall = sync_r[2] & ~sync_r[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: deserialises 11-bit PS/2 device-to-host frames,
// validates them and queues scan-code bytes in an 8-slot FIFO that holds
// at most 7 bytes, popped with an active-low nextdata_n handshake.
// Optional build macro: PS2_PARITY_CHECK_EN (when defined the odd parity
// bit is checked as well as start and stop bits).
import ps2_pkg::*;

module ps2_keyboard_rx (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  logic                  fall_s;
  logic [FRAME_BITS-1:0] buffer_r;
  logic [CNT_W-1:0]      count_r;
  logic [PTR_W-1:0]      w_ptr_r;
  logic [PTR_W-1:0]      r_ptr_r;
  logic                  ready_r;
  logic                  overflow_r;
  logic [7:0]            fifo_r [FIFO_DEPTH];

  logic                  frame_end_s;
  logic                  frame_ok_s;
  logic                  full_s;
  logic                  wr_s;
  logic                  drop_s;
  logic                  pop_s;
  logic [PTR_W-1:0]      w_ptr_inc_s;
  logic [PTR_W-1:0]      r_ptr_inc_s;

  ps2_clk_sync u_sync (
    .clk     (clk),
    .clrn    (clrn),
    .ps2_clk (ps2_clk),
    .fall    (fall_s)
  );

  // Frame validation, FIFO full detection and write/pop decisions.
  always_comb begin
    frame_end_s = 1'b0;
    frame_ok_s  = 1'b0;
    full_s      = 1'b0;
    wr_s        = 1'b0;
    drop_s      = 1'b0;
    pop_s       = 1'b0;
    w_ptr_inc_s = w_ptr_r + 3'd1;
    r_ptr_inc_s = r_ptr_r + 3'd1;

    frame_end_s = fall_s & (count_r == LAST_BIT);
    // The stop bit is taken straight from the pin: it is being captured
    // on this very edge.
`ifdef PS2_PARITY_CHECK_EN
    frame_ok_s = (buffer_r[0] == 1'b0) & (ps2_data == 1'b1)
               & odd_parity_ok(buffer_r[9:1]);
`else
    frame_ok_s = (buffer_r[0] == 1'b0) & (ps2_data == 1'b1);
`endif
    full_s = (w_ptr_inc_s == r_ptr_r);
    wr_s   = frame_end_s & frame_ok_s & ~full_s;
    drop_s = frame_end_s & frame_ok_s & full_s;
    pop_s  = ready_r & ~nextdata_n;
  end

  // Bit capture: one bit per detected ps2_clk falling edge, count 0..10.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      buffer_r <= 11'd0;
      count_r  <= 4'd0;
    end else if (fall_s) begin
      buffer_r[count_r] <= ps2_data;
      if (count_r == LAST_BIT) begin
        count_r <= 4'd0;
      end else begin
        count_r <= count_r + 4'd1;
      end
    end else begin
      count_r <= count_r;
    end
  end

  // FIFO pointers and status flags; a write and a pop may share a cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      w_ptr_r    <= 3'd0;
      r_ptr_r    <= 3'd0;
      ready_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_s) begin
        w_ptr_r <= w_ptr_inc_s;
      end
      if (pop_s) begin
        r_ptr_r <= r_ptr_inc_s;
      end
      if (wr_s) begin
        ready_r <= 1'b1;
      end else if (pop_s && (r_ptr_inc_s == w_ptr_r)) begin
        ready_r <= 1'b0;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FIFO storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      fifo_r[w_ptr_r] <= buffer_r[8:1];
    end
  end

  assign data     = fifo_r[r_ptr_r];
  assign ready    = ready_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed PS/2 frames with
// hand-computed expected bytes and flag states.
import ps2_pkg::*;

module tb_ps2_keyboard_rx;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  ps2_keyboard_rx dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_start,
                                             input logic bad_par, input logic bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, bad_start};
  endfunction

  task automatic send_frame(input logic [10:0] f);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); ps2_data = f[i];
      repeat (5) @(negedge clk); ps2_clk = 1'b0;
      repeat (10) @(negedge clk); ps2_clk = 1'b1;
      repeat (5) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(make_frame(b, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic pop_one;
    @(negedge clk); nextdata_n = 1'b0;
    @(negedge clk); nextdata_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk); clrn = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else pass_cnt++;
    total_cnt++; if (dut.count_r !== 4'd0) $display("FAIL reset_count got=%0d exp=0", dut.count_r); else pass_cnt++;
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (ready !== 1'b0) $display("FAIL post_reset_ready got=%b exp=0", ready); else pass_cnt++;
  endtask

  task automatic test_single;
    send_byte(8'h1C);
    total_cnt++; if (ready !== 1'b1) $display("FAIL single_ready got=%b exp=1", ready); else pass_cnt++;
    total_cnt++; if (data !== 8'h1C) $display("FAIL single_data got=%h exp=1c", data); else pass_cnt++;
    @(negedge clk); nextdata_n = 1'b0;
    repeat (2) @(negedge clk); nextdata_n = 1'b1;
    total_cnt++; if (ready !== 1'b0) $display("FAIL single_pop_ready got=%b exp=0", ready); else pass_cnt++;
    total_cnt++; if (dut.r_ptr_r !== 3'd1) $display("FAIL single_one_pop r_ptr got=%0d exp=1", dut.r_ptr_r); else pass_cnt++;
  endtask

  task automatic test_break;
    send_byte(BREAK_CODE);
    total_cnt++; if (data !== 8'hF0) $display("FAIL break_f0 got=%h exp=f0", data); else pass_cnt++;
    pop_one();
    total_cnt++; if (ready !== 1'b0) $display("FAIL break_ready1 got=%b exp=0", ready); else pass_cnt++;
    send_byte(KEY_A);
    total_cnt++; if (data !== 8'h1C) $display("FAIL break_1c got=%h exp=1c", data); else pass_cnt++;
    pop_one();
    total_cnt++; if (ready !== 1'b0) $display("FAIL break_ready2 got=%b exp=0", ready); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL break_overflow got=%b exp=0", overflow); else pass_cnt++;
  endtask

  task automatic test_burst;
    logic [7:0] exp_b [5];
    exp_b = '{8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B};
    for (int i = 0; i < 5; i++) send_byte(exp_b[i]);
    total_cnt++; if (ready !== 1'b1) $display("FAIL burst_ready got=%b exp=1", ready); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (data !== exp_b[i]) $display("FAIL burst_data[%0d] got=%h exp=%h", i, data, exp_b[i]); else pass_cnt++;
      pop_one();
      total_cnt++;
      if (ready !== (i < 4)) $display("FAIL burst_ready[%0d] got=%b exp=%b", i, ready, (i < 4)); else pass_cnt++;
    end
  endtask

  task automatic test_level_pop;
    send_byte(8'h21);
    send_byte(8'h22);
    @(negedge clk); nextdata_n = 1'b0;
    repeat (4) @(negedge clk); nextdata_n = 1'b1;
    total_cnt++; if (ready !== 1'b0) $display("FAIL level_ready got=%b exp=0", ready); else pass_cnt++;
    send_byte(KEY_S);
    total_cnt++; if (data !== 8'h1B) $display("FAIL level_next got=%h exp=1b", data); else pass_cnt++;
    pop_one();
  endtask

  task automatic test_error;
    send_frame(make_frame(8'h1C, 1'b0, 1'b0, 1'b1));
    total_cnt++; if (ready !== 1'b0) $display("FAIL err_stop_ready got=%b exp=0", ready); else pass_cnt++;
    send_frame(make_frame(8'h1C, 1'b1, 1'b0, 1'b0));
    total_cnt++; if (ready !== 1'b0) $display("FAIL err_start_ready got=%b exp=0", ready); else pass_cnt++;
    send_frame(make_frame(8'h1C, 1'b0, 1'b1, 1'b0));
`ifdef PS2_PARITY_CHECK_EN
    total_cnt++; if (ready !== 1'b0) $display("FAIL err_parity_ready got=%b exp=0", ready); else pass_cnt++;
`else
    total_cnt++; if (ready !== 1'b1) $display("FAIL parity_ignored_ready got=%b exp=1", ready); else pass_cnt++;
    total_cnt++; if (data !== 8'h1C) $display("FAIL parity_ignored_data got=%h exp=1c", data); else pass_cnt++;
    pop_one();
`endif
    total_cnt++; if (overflow !== 1'b0) $display("FAIL err_overflow got=%b exp=0", overflow); else pass_cnt++;
    send_byte(KEY_A);
    total_cnt++; if (ready !== 1'b1) $display("FAIL err_good_ready got=%b exp=1", ready); else pass_cnt++;
    total_cnt++; if (data !== 8'h1C) $display("FAIL err_good_data got=%h exp=1c", data); else pass_cnt++;
    pop_one();
    total_cnt++; if (ready !== 1'b0) $display("FAIL err_good_pop got=%b exp=0", ready); else pass_cnt++;
  endtask

  task automatic test_overflow;
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 8'h30 + 8'(i);
      send_byte(b);
      if (i == 6) begin
        total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_after7 got=%b exp=0", overflow); else pass_cnt++;
      end
    end
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_after8 got=%b exp=1", overflow); else pass_cnt++;
    total_cnt++; if (ready !== 1'b1) $display("FAIL ovf_ready got=%b exp=1", ready); else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      b = 8'h30 + 8'(i);
      total_cnt++; if (data !== b) $display("FAIL ovf_data[%0d] got=%h exp=%h", i, data, b); else pass_cnt++;
      pop_one();
    end
    total_cnt++; if (ready !== 1'b0) $display("FAIL ovf_empty got=%b exp=0", ready); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_break();
    test_burst();
    test_level_pop();
    test_error();
    test_overflow();
    test_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
